fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit core. Holds the program counter, drives the instruction-memory address, and registers the returned instruction into an instruction register (IR) for the decode stage. Decode receives instructions through a valid/ready handshake. Unconditional jumps (opcode `11`) are resolved and consumed here and never reach decode. A jump to itself, or a PC outside the program image, stops fetch in a sticky HALT state.

## Interface
Parameters:
- `MEM_DEPTH`, default 26: number of valid instruction words; a PC ≥ `MEM_DEPTH` is out of range.
- `RESET_PC`, default 8'h00: PC value loaded on reset.

Ports:
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `ADD`  out  8  instruction-memory address; combinational copy of the PC register.
- `Ins`  in  8  instruction word from instruction memory, combinational from `ADD`.
- `IR`  out  8  registered instruction presented to decode.
- `IR_PC`  out  8  address the word in `IR` was fetched from.
- `VALID`  out  1  `IR` and `IR_PC` hold an instruction not yet accepted.
- `READY`  in  1  decode can accept this cycle.
- `HALTED`  out  1  fetch has stopped (sticky until reset).

## Operation
- Opcode is `Ins[7:6]`. For a jump, `imm6 = Ins[5:0]` is two's complement.
- Jump target = `PC + 1 + sext(imm6)`, computed modulo 256.
- State machine has two states, FETCH and HALT. Reset enters FETCH.
- A transfer to decode occurs on any cycle with `VALID && READY`.
- The advance condition is `!VALID || READY`. In FETCH with advance true, the stage acts on `Ins` at the current PC:
  - PC ≥ `MEM_DEPTH`: go to HALT, `VALID <= 0`.
  - Opcode `00`, `01` or `10`: `IR <= Ins`, `IR_PC <= PC`, `VALID <= 1`, `PC <= PC+1`.
  - Opcode `11`, target == PC (imm6 = 6'h3F): go to HALT, `VALID <= 0`, PC unchanged.
  - Opcode `11`, any other target: `PC <= target`, `VALID <= 0` (one bubble). A target ≥ `MEM_DEPTH` halts on the next evaluation.
- When advance is false (`VALID && !READY`), `PC`, `IR`, `IR_PC` and `VALID` all hold.
- In HALT:
  - PC is frozen.
  - Any pending `VALID` instruction still completes its handshake; `VALID` then falls and stays 0.
  - `HALTED` is 1 from the HALT-entry edge onward.
- A PC increment that passes 8'hFF wraps to 8'h00. With `MEM_DEPTH` ≤ 256, the range check halts fetch before that happens.

## Timing
- Reset values (async, while `RST_N` = 0): `PC` = `RESET_PC` (so `ADD` = `RESET_PC`), `IR` = 8'h00, `IR_PC` = 8'h00, `VALID` = 0, `HALTED` = 0, state FETCH.
- Latency from `ADD` change to the word appearing in `IR`: 1 cycle. The first `VALID` comes on the first rising edge after `RST_N` deasserts.
- Sustained throughput is 1 instruction per cycle while `READY` = 1.
- Each taken jump costs exactly 1 bubble cycle (`VALID` = 0).
- `READY` is sampled only while `VALID` = 1. Decode must not depend on `IR` while `VALID` = 0.
- Jump after a stall: when a jump sits at PC while decode is stalled, the jump is resolved on the same edge that the held instruction transfers.
- Reset mid-operation: asserting `RST_N` low at any time, including mid-stall or in HALT, returns all outputs to their reset values immediately. No handshake completes during reset.

## Structure
- Shared package `core_pkg`:
  - opcode constants `OP_ALU` = 2'b00, `OP_LD` = 2'b01, `OP_ST` = 2'b10, `OP_JMP` = 2'b11;
  - the fetch state encoding (FETCH, HALT);
  - a `sext6to8` function.
- Single module, with no sub-module. Jump-target and next-PC logic are one combinational block feeding the PC, IR and state registers.

## Test plan
- **Reset then free run**: with the standard program image and `READY` = 1, the IR sequence after reset is 0x48, 0x49, 0x65, 0x1B, then one bubble cycle (jump at PC 4, imm +1, target 6), then 0xAE with `IR_PC` = 6. PC 5 is never issued.
- **Back-pressure**: hold `READY` = 0 for 3 cycles while `IR` = 0x65. `IR` and `IR_PC` = 2 stay stable and `ADD` stays 3. The instruction 0x65 transfers exactly once, on the cycle `READY` returns to 1.
- **Self-loop**: use an image with 8'hFF at address 3. After the instructions at 0–2 issue, `HALTED` rises, `VALID` stays 0 and `ADD` stays 3 for 20 or more cycles.
- **Out of range**: with `MEM_DEPTH` = 4 and no jumps, instructions 0–3 issue, then `HALTED` = 1 with PC = 4 and no further `VALID`.
- **Back-to-back jumps**: with 0xC1 at 20 and 21 and 0xC2 at 22, starting from PC 20, the fetch order is 20 → 22 → 25 with 2 bubbles. The next issued word is 0x06 with `IR_PC` = 25.
- **Reset mid-stall**: drop `RST_N` while `VALID` = 1 and `READY` = 0. `VALID`, `HALTED`, `IR` and `PC` go to 0 asynchronously. After release, the first issued instruction is 0x48 from PC 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: opcode map, fetch FSM encoding,
// and the immediate sign-extension helper.
package core_pkg;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_e;

  function automatic logic [7:0] sext6to8(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR register with valid/ready to decode.
// Unconditional jumps are resolved here and never reach decode.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 26,
  parameter logic [7:0]  RESET_PC  = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic [7:0] ADD,
  input  logic [7:0] Ins,
  output logic [7:0] IR,
  output logic [7:0] IR_PC,
  output logic       VALID,
  input  logic       READY,
  output logic       HALTED
);

  fetch_state_e r_state, w_state_nxt;
  logic [7:0]   r_pc, r_ir, r_ir_pc;
  logic         r_valid;
  logic [7:0]   w_pc_nxt, w_ir_nxt, w_ir_pc_nxt, w_target;
  logic         w_valid_nxt, w_advance, w_oob;

  assign w_advance = !r_valid || READY;
  assign w_oob     = ({1'b0, r_pc} >= 9'(MEM_DEPTH));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 8'h00;
      r_ir_pc <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_ir_pc <= w_ir_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state, jump target and next-PC in one block so the range check,
  // opcode decode and self-jump detection all see the same PC.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_ir_pc_nxt = r_ir_pc;
    w_valid_nxt = r_valid;
    w_target    = r_pc + 8'd1 + sext6to8(Ins[5:0]);
    if (r_state == ST_HALT) begin
      w_valid_nxt = r_valid && !READY;
    end else if (w_advance) begin
      if (w_oob) begin
        w_state_nxt = ST_HALT;
        w_valid_nxt = 1'b0;
      end else if (Ins[7:6] != OP_JMP) begin
        w_ir_nxt    = Ins;
        w_ir_pc_nxt = r_pc;
        w_valid_nxt = 1'b1;
        w_pc_nxt    = r_pc + 8'd1;
      end else if (w_target == r_pc) begin
        w_state_nxt = ST_HALT;
        w_valid_nxt = 1'b0;
      end else begin
        w_pc_nxt    = w_target;
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    ADD    = r_pc;
    IR     = r_ir;
    IR_PC  = r_ir_pc;
    VALID  = r_valid;
    HALTED = (r_state == ST_HALT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for the reset/back-pressure window,
// a program-walk scoreboard for issued instructions, and corner sequences.
module tb_fetch_unit;

  typedef struct {
    logic       rdy;
    logic       valid;
    logic [7:0] ir;
    logic [7:0] ir_pc;
    logic [7:0] add;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ins;
  } xfer_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       READY = 1'b0;
  logic [7:0] ADD, IR, IR_PC, Ins;
  logic       VALID, HALTED;
  logic [7:0] ADD1, IR1, IR_PC1, Ins1;
  logic       VALID1, HALTED1;

  logic [7:0] mem [256];
  xfer_t      sbq[$];
  bit         sb_en = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;
  vec_t       vt[11];

  assign Ins  = mem[ADD];
  assign Ins1 = mem[ADD1];

  always #5 CLK = ~CLK;

  fetch_unit u0 (
    .CLK(CLK), .RST_N(RST_N), .ADD(ADD), .Ins(Ins), .IR(IR), .IR_PC(IR_PC),
    .VALID(VALID), .READY(READY), .HALTED(HALTED)
  );

  fetch_unit #(.MEM_DEPTH(4)) u1 (
    .CLK(CLK), .RST_N(RST_N), .ADD(ADD1), .Ins(Ins1), .IR(IR1), .IR_PC(IR_PC1),
    .VALID(VALID1), .READY(READY), .HALTED(HALTED1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected issue order, derived by walking the image as a program.
  task automatic load_model(input int depth, input logic [7:0] pc0);
    logic [7:0] pc, t, w;
    sbq.delete();
    pc = pc0;
    for (int i = 0; i < 300; i++) begin
      if (int'(pc) >= depth) break;
      w = mem[pc];
      if (w[7:6] == 2'b11) begin
        t = pc + 8'd1 + {{2{w[5]}}, w[5:0]};
        if (t == pc) break;
        pc = t;
      end else begin
        sbq.push_back('{pc: pc, ins: w});
        pc = pc + 8'd1;
      end
    end
  endtask

  task automatic sb_pop();
    xfer_t e;
    if (sbq.size() == 0) begin
      chk("sb_extra_issue", {IR_PC, IR}, 32'hFFFF);
    end else begin
      e = sbq.pop_front();
      chk("sb_issue", {IR_PC, IR}, {e.pc, e.ins});
    end
  endtask

  // Drive READY mid-cycle, log any transfer, advance to the next negedge.
  task automatic tick(input logic rdy);
    READY = rdy;
    if (sb_en && VALID && rdy) sb_pop();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    READY = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic load_image();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h48; mem[1] = 8'h49; mem[2] = 8'h65; mem[3] = 8'h1B;
    mem[4] = 8'hC1; mem[5] = 8'h77; mem[6] = 8'hAE;
    for (int i = 7; i < 20; i++) mem[i] = 8'(8'h10 + i);
    mem[20] = 8'hC1; mem[21] = 8'hC1; mem[22] = 8'hC2;
    mem[23] = 8'h55; mem[24] = 8'h55; mem[25] = 8'h06;
  endtask

  initial begin
    int k;
    load_image();
    vt[0]  = '{1'b1, 1'b1, 8'h48, 8'd0, 8'd1};
    vt[1]  = '{1'b1, 1'b1, 8'h49, 8'd1, 8'd2};
    vt[2]  = '{1'b1, 1'b1, 8'h65, 8'd2, 8'd3};
    vt[3]  = '{1'b0, 1'b1, 8'h65, 8'd2, 8'd3};
    vt[4]  = '{1'b0, 1'b1, 8'h65, 8'd2, 8'd3};
    vt[5]  = '{1'b0, 1'b1, 8'h65, 8'd2, 8'd3};
    vt[6]  = '{1'b1, 1'b1, 8'h1B, 8'd3, 8'd4};
    vt[7]  = '{1'b1, 1'b0, 8'h1B, 8'd3, 8'd6};
    vt[8]  = '{1'b1, 1'b1, 8'hAE, 8'd6, 8'd7};
    vt[9]  = '{1'b0, 1'b1, 8'hAE, 8'd6, 8'd7};
    vt[10] = '{1'b1, 1'b1, 8'h17, 8'd7, 8'd8};

    #2;
    // Reset state and the table window (free run + back-pressure on 0x65)
    READY = 1'b0;
    RST_N = 1'b0;
    #3;
    chk("rst_valid", VALID, 0); chk("rst_add", ADD, 0); chk("rst_ir", IR, 0);
    chk("rst_ir_pc", IR_PC, 0); chk("rst_halted", HALTED, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    load_model(26, 8'h00);
    sb_en = 1'b1;
    foreach (vt[i]) begin
      tick(vt[i].rdy);
      chk($sformatf("vec%0d", i), {VALID, IR, IR_PC, ADD, HALTED},
          {vt[i].valid, vt[i].ir, vt[i].ir_pc, vt[i].add, 1'b0});
    end

    // Back-to-back jumps 20 -> 22 -> 25, then range halt at 26
    k = 0;
    while (!(VALID && IR_PC == 8'd19) && k < 100) begin tick(1'b1); k++; end
    chk("reach_pc19", k < 100, 1);
    tick(1'b1); chk("b2b_bubble1", {VALID, ADD}, {1'b0, 8'd22});
    tick(1'b1); chk("b2b_bubble2", {VALID, ADD}, {1'b0, 8'd25});
    tick(1'b1); chk("b2b_issue25", {VALID, IR, IR_PC}, {1'b1, 8'h06, 8'd25});
    tick(1'b1); chk("oob_halt", {HALTED, VALID, ADD}, {1'b1, 1'b0, 8'd26});
    for (int i = 0; i < 5; i++) tick(1'b1);
    chk("halt_sticky", {HALTED, VALID, ADD}, {1'b1, 1'b0, 8'd26});
    chk("sb_drained", sbq.size(), 0);

    // Random back-pressure through the whole program
    do_reset();
    load_model(26, 8'h00);
    k = 0;
    while (!(HALTED && !VALID) && k < 600) begin tick(1'($urandom_range(0, 1))); k++; end
    chk("rand_done", k < 600, 1);
    chk("rand_end_add", ADD, 26);
    chk("rand_sb_drained", sbq.size(), 0);

    // Reset while stalled
    do_reset();
    load_model(26, 8'h00);
    tick(1'b1);
    tick(1'b0);
    chk("pre_rst_stall", {VALID, IR}, {1'b1, 8'h48});
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_state", {VALID, HALTED, IR, IR_PC, ADD}, {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    @(negedge CLK);
    chk("midrst_hold", {VALID, ADD}, {1'b0, 8'h00});
    RST_N = 1'b1;
    tick(1'b1);
    chk("postrst_first", {VALID, IR, IR_PC}, {1'b1, 8'h48, 8'd0});

    // Self-loop at address 3
    mem[3] = 8'hFF;
    do_reset();
    load_model(26, 8'h00);
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("self_halt", {HALTED, VALID, ADD}, {1'b1, 1'b0, 8'd3});
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      if (VALID || !HALTED || ADD != 8'd3) chk("self_sticky", {HALTED, VALID, ADD}, {1'b1, 1'b0, 8'd3});
    end
    chk("self_end", {HALTED, VALID, ADD}, {1'b1, 1'b0, 8'd3});
    chk("self_sb_drained", sbq.size(), 0);
    mem[3] = 8'h1B;

    // Out of range with MEM_DEPTH = 4 (second instance)
    sb_en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      chk($sformatf("oob4_issue%0d", i), {VALID1, IR1, IR_PC1}, {1'b1, mem[i], 8'(i)});
    end
    tick(1'b1);
    chk("oob4_halt", {HALTED1, VALID1, ADD1}, {1'b1, 1'b0, 8'd4});
    for (int i = 0; i < 5; i++) tick(1'b1);
    chk("oob4_sticky", {HALTED1, VALID1, ADD1}, {1'b1, 1'b0, 8'd4});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
